code_mem_loader: RTL and testbench
==================================

// Module: code_mem_loader
// PURPOSE
// - Parametrised, byte-programmable code memory for the debug harness. Loads a byte stream over a
//   valid/ready handshake with an auto-incrementing pointer. Serves word fetches to the core under debug.
// - Sits between the host/UI programming path and the DUT instruction-fetch port.
// - Generalises the fixed 32-byte code ROM with: configurable depth and word width, a load FSM,
//   an overflow error flag, and a registered word fetch port.
// PARAMETERS
// - NUM_WORDS   8                               number of code words (>=2)
// - WORD_BYTES  4                               bytes per word, little-endian lanes
// - BYTE_ADDR_W $clog2(NUM_WORDS*WORD_BYTES)    byte pointer width (derived)
// - WORD_ADDR_W $clog2(NUM_WORDS)               fetch address width (derived)
// PORTS
// - clk               in   1                 clock
// - reset_code_rom_n  in   1                 async active-low reset, clears memory and FSM
// - load_start        in   1                 1-cycle pulse: begin or restart a load at load_base
// - load_base         in   BYTE_ADDR_W       start byte address, sampled on load_start
// - load_data         in   8                 stream byte
// - load_valid        in   1                 load_data valid
// - load_last         in   1                 marks final byte; qualified by the transfer
// - load_ready        out  1                 block accepts a byte this cycle
// - load_done         out  1                 level: last byte stored
// - load_err          out  1                 level: pointer overflow, sticky until load_start
// - load_count        out  BYTE_ADDR_W+1     bytes accepted since last load_start
// - fetch_en          in   1                 fetch request
// - fetch_addr        in   WORD_ADDR_W       word address
// - fetch_data        out  8*WORD_BYTES      fetched word
// - fetch_valid       out  1                 fetch_data valid, 1 cycle after fetch_en
// BEHAVIOUR
// - Reset:
//   - memory all 0
//   - state CL_IDLE; internal pointer 0
//   - load_ready, load_done, load_err, fetch_valid = 0; load_count = 0; fetch_data = 0
// - FSM states: CL_IDLE, CL_LOAD, CL_DONE, CL_ERR.
//   - load_start in any state: go to CL_LOAD. Pointer <= load_base. Count <= 0. done/err cleared.
//   - load_start has priority over a same-cycle transfer; that transfer's byte is dropped.
// - load_ready = (state==CL_LOAD), combinational from state.
// - Transfer = load_valid & load_ready:
//   - byte written to word ptr/WORD_BYTES, lane ptr%WORD_BYTES (lane0 = bits 7:0)
//   - ptr++ and count++
// - Transfer with load_last -> CL_DONE.
// - Transfer at ptr==NUM_WORDS*WORD_BYTES-1 without load_last: byte is written, then -> CL_ERR.
//   The pointer never wraps.
// - CL_DONE: load_done=1. CL_ERR: load_err=1. Both hold until load_start or reset.
// - Bytes already written are never rolled back: not on abort, not on error.
// - Fetch, 1-cycle latency:
//   - fetch_data <= mem[fetch_addr] when fetch_en; fetch_valid <= fetch_en
//   - fetch_data holds its value when fetch_en=0
//   - legal in every state
//   - same-cycle write to the fetched word returns the pre-write value (read-before-write)
//   - fetch_addr >= NUM_WORDS returns 0
// - Reset asserted mid-load: immediate return to reset state; partial data is lost.
// CONFIGURATION
// - Macro CODE_MEM_CHECKSUM_EN:
//   - defined: extra output load_checksum[7:0]
//     - mod-256 sum of all bytes accepted since last load_start
//     - reset 0; cleared on load_start
//   - undefined: port and logic absent; behaviour otherwise identical.
// STRUCTURE
// - Shared package debug_pkg:
//   - enum code_load_state_t {CL_IDLE, CL_LOAD, CL_DONE, CL_ERR}
//   - debug command constants (IDLE/RUN/HALT/STEP)
//   - CODE_BYTE_W = 8
// - Sub-module code_mem_bank: byte-lane-writable storage array, async clear, registered read port.
// - Top level holds the FSM, pointer/count and the optional checksum.
// TESTING
// - Reset, then fetch_en with fetch_addr=0: fetch_valid=1 next cycle, fetch_data=0x00000000.
//   load_ready=0.
// - load_start with base=0. Stream 0x11..0x88 (8 bytes), last on the 8th.
//   Expect: word0=0x44332211, word1=0x88776655, load_done=1, load_count=8.
//   With CODE_MEM_CHECKSUM_EN: load_checksum=0x64.
// - Unaligned load with base=5, bytes 0xAA,0xBB (last), load_valid gap of 3 cycles between them.
//   Expect: word1=0x00BBAA00, count=2.
// - Overflow with base=30, 3 bytes and no last. Expect:
//   - bytes 30 and 31 written
//   - load_err=1 and load_ready=0 after the 2nd byte
//   - 3rd byte not accepted; count=2
// - Abort: load_start(base=0) after 3 of 8 bytes. Expect count=0 and the 3 written bytes retained.
//   A same-cycle valid byte is dropped.
// - Assert reset_code_rom_n mid-load, then release. Expect:
//   - all words read 0x00000000
//   - state CL_IDLE; done, err and count all 0

Source files
------------

// File: rtl/debug_pkg.sv
// Shared debug-harness definitions: code-load FSM states, debug command codes, byte width.
package debug_pkg;

  localparam int CODE_BYTE_W = 8;

  typedef enum logic [1:0] {
    CL_IDLE,
    CL_LOAD,
    CL_DONE,
    CL_ERR
  } code_load_state_t;

  localparam logic [1:0] DBG_CMD_IDLE = 2'd0;
  localparam logic [1:0] DBG_CMD_RUN  = 2'd1;
  localparam logic [1:0] DBG_CMD_HALT = 2'd2;
  localparam logic [1:0] DBG_CMD_STEP = 2'd3;

endpackage

// File: rtl/code_mem_bank.sv
// Byte-lane-writable code storage with async clear and a registered, read-before-write fetch port.
module code_mem_bank
  import debug_pkg::*;
#(
  parameter int NUM_WORDS   = 8,
  parameter int WORD_BYTES  = 4,
  parameter int WORD_ADDR_W = $clog2(NUM_WORDS),
  parameter int LANE_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
  input  logic                              clk,
  input  logic                              reset_code_rom_n,
  input  logic                              i_wr_en,
  input  logic [WORD_ADDR_W-1:0]            i_wr_word,
  input  logic [LANE_W-1:0]                 i_wr_lane,
  input  logic [CODE_BYTE_W-1:0]            i_wr_byte,
  input  logic                              i_rd_en,
  input  logic [WORD_ADDR_W-1:0]            i_rd_addr,
  output logic [CODE_BYTE_W*WORD_BYTES-1:0] o_rd_data,
  output logic                              o_rd_valid
);

  logic [WORD_BYTES-1:0][CODE_BYTE_W-1:0] r_mem [NUM_WORDS];
  logic [CODE_BYTE_W*WORD_BYTES-1:0]      w_rdWord;
  logic [CODE_BYTE_W*WORD_BYTES-1:0]      r_rdData;
  logic                                   r_rdValid;

  // Decoded lookup so an address with no backing word reads as zero.
  always_comb begin
    w_rdWord = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (i_rd_addr == WORD_ADDR_W'(i)) w_rdWord = r_mem[i];
    end
  end

  always_ff @(posedge clk or negedge reset_code_rom_n) begin
    if (!reset_code_rom_n) begin
      for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        for (int j = 0; j < WORD_BYTES; j++) begin
          if (i_wr_word == WORD_ADDR_W'(i) && i_wr_lane == LANE_W'(j)) r_mem[i][j] <= i_wr_byte;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_code_rom_n) begin
    if (!reset_code_rom_n) begin
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= i_rd_en;
      if (i_rd_en) r_rdData <= w_rdWord;
    end
  end

  assign o_rd_data  = r_rdData;
  assign o_rd_valid = r_rdValid;

endmodule

// File: rtl/code_mem_loader.sv
// Byte-stream code memory loader with word fetch port for the debug harness.
// Optional load checksum output enabled by defining CODE_MEM_CHECKSUM_EN.
module code_mem_loader
  import debug_pkg::*;
#(
  parameter int NUM_WORDS   = 8,
  parameter int WORD_BYTES  = 4,
  parameter int BYTE_ADDR_W = $clog2(NUM_WORDS*WORD_BYTES),
  parameter int WORD_ADDR_W = $clog2(NUM_WORDS)
) (
  input  logic                              clk,
  input  logic                              reset_code_rom_n,
  input  logic                              load_start,
  input  logic [BYTE_ADDR_W-1:0]            load_base,
  input  logic [CODE_BYTE_W-1:0]            load_data,
  input  logic                              load_valid,
  input  logic                              load_last,
  output logic                              load_ready,
  output logic                              load_done,
  output logic                              load_err,
  output logic [BYTE_ADDR_W:0]              load_count,
`ifdef CODE_MEM_CHECKSUM_EN
  output logic [7:0]                        load_checksum,
`endif
  input  logic                              fetch_en,
  input  logic [WORD_ADDR_W-1:0]            fetch_addr,
  output logic [CODE_BYTE_W*WORD_BYTES-1:0] fetch_data,
  output logic                              fetch_valid
);

  localparam int LANE_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TOTAL_BYTES = NUM_WORDS * WORD_BYTES;
  localparam logic [BYTE_ADDR_W-1:0] LAST_PTR = BYTE_ADDR_W'(TOTAL_BYTES - 1);

  code_load_state_t         r_state, w_nextState;
  logic [BYTE_ADDR_W-1:0]   r_ptr;
  logic [BYTE_ADDR_W:0]     r_count;
  logic                     w_xfer;
  logic [WORD_ADDR_W-1:0]   w_wrWord;
  logic [LANE_W-1:0]        w_wrLane;

  // A restart wins over a same-cycle byte, which is then dropped.
  assign w_xfer   = load_valid & load_ready & ~load_start;
  assign w_wrWord = WORD_ADDR_W'(int'(r_ptr) / WORD_BYTES);
  assign w_wrLane = LANE_W'(int'(r_ptr) % WORD_BYTES);

  always_ff @(posedge clk or negedge reset_code_rom_n) begin
    if (!reset_code_rom_n) r_state <= CL_IDLE;
    else                   r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (load_start) begin
      w_nextState = CL_LOAD;
    end else if (w_xfer) begin
      if (load_last)              w_nextState = CL_DONE;
      else if (r_ptr == LAST_PTR) w_nextState = CL_ERR;
    end
  end

  always_comb begin
    load_ready = (r_state == CL_LOAD);
    load_done  = (r_state == CL_DONE);
    load_err   = (r_state == CL_ERR);
  end

  // The pointer saturates at the last byte; overflow is reported via CL_ERR instead of wrapping.
  always_ff @(posedge clk or negedge reset_code_rom_n) begin
    if (!reset_code_rom_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (load_start) begin
      r_ptr   <= load_base;
      r_count <= '0;
    end else if (w_xfer) begin
      r_count <= r_count + 1'b1;
      if (r_ptr != LAST_PTR) r_ptr <= r_ptr + 1'b1;
    end
  end

  assign load_count = r_count;

`ifdef CODE_MEM_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge clk or negedge reset_code_rom_n) begin
    if (!reset_code_rom_n) r_checksum <= '0;
    else if (load_start)   r_checksum <= '0;
    else if (w_xfer)       r_checksum <= r_checksum + load_data;
  end

  assign load_checksum = r_checksum;
`endif

  code_mem_bank #(
    .NUM_WORDS   (NUM_WORDS),
    .WORD_BYTES  (WORD_BYTES),
    .WORD_ADDR_W (WORD_ADDR_W),
    .LANE_W      (LANE_W)
  ) u_bank (
    .clk              (clk),
    .reset_code_rom_n (reset_code_rom_n),
    .i_wr_en          (w_xfer),
    .i_wr_word        (w_wrWord),
    .i_wr_lane        (w_wrLane),
    .i_wr_byte        (load_data),
    .i_rd_en          (fetch_en),
    .i_rd_addr        (fetch_addr),
    .o_rd_data        (fetch_data),
    .o_rd_valid       (fetch_valid)
  );

endmodule

// File: tb/tb_code_mem_loader.sv
// Directed, table-driven bench for code_mem_loader (checksum checks active with CODE_MEM_CHECKSUM_EN).
module tb_code_mem_loader;

  logic        clk = 1'b0;
  logic        reset_code_rom_n;
  logic        load_start;
  logic [4:0]  load_base;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        load_err;
  logic [5:0]  load_count;
`ifdef CODE_MEM_CHECKSUM_EN
  logic [7:0]  load_checksum;
`endif
  logic        fetch_en;
  logic [2:0]  fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;

  int nCompared = 0;
  int nMismatch = 0;

  typedef struct {
    logic       start;
    logic [4:0] base;
    logic       valid;
    logic       last;
    logic [7:0] data;
    logic       expReady;
    logic       expDone;
    logic       expErr;
    logic [5:0] expCount;
  } step_t;

  step_t steps[$];

  code_mem_loader dut (
    .clk              (clk),
    .reset_code_rom_n (reset_code_rom_n),
    .load_start       (load_start),
    .load_base        (load_base),
    .load_data        (load_data),
    .load_valid       (load_valid),
    .load_last        (load_last),
    .load_ready       (load_ready),
    .load_done        (load_done),
    .load_err         (load_err),
    .load_count       (load_count),
`ifdef CODE_MEM_CHECKSUM_EN
    .load_checksum    (load_checksum),
`endif
    .fetch_en         (fetch_en),
    .fetch_addr       (fetch_addr),
    .fetch_data       (fetch_data),
    .fetch_valid      (fetch_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic step_t mkStep(logic start, logic [4:0] base, logic valid, logic last,
                                   logic [7:0] data, logic expReady, logic expDone,
                                   logic expErr, logic [5:0] expCount);
    step_t s;
    s.start = start; s.base = base; s.valid = valid; s.last = last; s.data = data;
    s.expReady = expReady; s.expDone = expDone; s.expErr = expErr; s.expCount = expCount;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [4:0] base, input logic valid,
                               input logic last, input logic [7:0] data);
    load_start = start;
    load_base  = base;
    load_valid = valid;
    load_last  = last;
    load_data  = data;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic checkStatus(input string tag, input logic expReady, input logic expDone,
                             input logic expErr, input logic [5:0] expCount);
    checkOutput({tag, " ready"}, 32'(load_ready), 32'(expReady));
    checkOutput({tag, " done"},  32'(load_done),  32'(expDone));
    checkOutput({tag, " err"},   32'(load_err),   32'(expErr));
    checkOutput({tag, " count"}, 32'(load_count), 32'(expCount));
  endtask

  task automatic runSteps(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(steps[i].start, steps[i].base, steps[i].valid, steps[i].last, steps[i].data);
      checkStatus($sformatf("step%0d", i), steps[i].expReady, steps[i].expDone,
                  steps[i].expErr, steps[i].expCount);
    end
  endtask

  task automatic fetchCheck(input string name, input logic [2:0] addr, input logic [31:0] expected);
    fetch_en   = 1'b1;
    fetch_addr = addr;
    @(posedge clk);
    #1;
    fetch_en = 1'b0;
    checkOutput({name, " valid"}, 32'(fetch_valid), 32'd1);
    checkOutput({name, " data"}, fetch_data, expected);
  endtask

  task automatic pulseReset();
    reset_code_rom_n = 1'b0;
    @(posedge clk);
    #1;
    reset_code_rom_n = 1'b1;
  endtask

  initial begin
    reset_code_rom_n = 1'b0;
    load_start = 1'b0; load_base = '0; load_data = '0; load_valid = 1'b0; load_last = 1'b0;
    fetch_en = 1'b0; fetch_addr = '0;

    // 8-byte aligned load (steps 0..8)
    steps.push_back(mkStep(1, 5'd0, 0, 0, 8'h00, 1, 0, 0, 6'd0));
    for (int k = 1; k <= 8; k++)
      steps.push_back(mkStep(0, 5'd0, 1, (k == 8), 8'(k * 8'h11), (k != 8), (k == 8), 0, 6'(k)));
    // Unaligned load with a 3-cycle valid gap (steps 9..14)
    steps.push_back(mkStep(1, 5'd5, 0, 0, 8'h00, 1, 0, 0, 6'd0));
    steps.push_back(mkStep(0, 5'd0, 1, 0, 8'hAA, 1, 0, 0, 6'd1));
    for (int k = 0; k < 3; k++)
      steps.push_back(mkStep(0, 5'd0, 0, 0, 8'h5A, 1, 0, 0, 6'd1));
    steps.push_back(mkStep(0, 5'd0, 1, 1, 8'hBB, 0, 1, 0, 6'd2));
    // Overflow from byte 30 (steps 15..18)
    steps.push_back(mkStep(1, 5'd30, 0, 0, 8'h00, 1, 0, 0, 6'd0));
    steps.push_back(mkStep(0, 5'd0, 1, 0, 8'hC1, 1, 0, 0, 6'd1));
    steps.push_back(mkStep(0, 5'd0, 1, 0, 8'hC2, 0, 0, 1, 6'd2));
    steps.push_back(mkStep(0, 5'd0, 1, 0, 8'hC3, 0, 0, 1, 6'd2));

    #12;
    checkStatus("in_reset", 0, 0, 0, 6'd0);
    @(posedge clk);
    #1;
    reset_code_rom_n = 1'b1;
    checkStatus("after_reset", 0, 0, 0, 6'd0);
    checkOutput("reset fetch_valid", 32'(fetch_valid), 32'd0);
    checkOutput("reset fetch_data", fetch_data, 32'h0);
`ifdef CODE_MEM_CHECKSUM_EN
    checkOutput("reset checksum", 32'(load_checksum), 32'h0);
`endif
    fetchCheck("reset word0", 3'd0, 32'h0000_0000);
    checkOutput("reset ready", 32'(load_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("fetch idle valid", 32'(fetch_valid), 32'd0);

    $display("[TB] aligned 8-byte load");
    runSteps(0, 8);
    fetchCheck("aligned word0", 3'd0, 32'h4433_2211);
    fetchCheck("aligned word1", 3'd1, 32'h8877_6655);
`ifdef CODE_MEM_CHECKSUM_EN
    checkOutput("aligned checksum", 32'(load_checksum), 32'h64);
`endif

    pulseReset();
    $display("[TB] unaligned load with gap");
    runSteps(9, 14);
    fetchCheck("unaligned word1", 3'd1, 32'h00BB_AA00);
`ifdef CODE_MEM_CHECKSUM_EN
    checkOutput("unaligned checksum", 32'(load_checksum), 32'h65);
`endif

    $display("[TB] overflow");
    runSteps(15, 18);
    fetchCheck("overflow word7", 3'd7, 32'hC2C1_0000);

    $display("[TB] abort and restart");
    applyStimulus(1, 5'd0, 0, 0, 8'h00);
    checkStatus("abort start", 1, 0, 0, 6'd0);
    fetch_en = 1'b1;
    fetch_addr = 3'd0;
    applyStimulus(0, 5'd0, 1, 0, 8'hD1);
    fetch_en = 1'b0;
    checkOutput("rbw fetch_valid", 32'(fetch_valid), 32'd1);
    checkOutput("rbw fetch_data", fetch_data, 32'h0000_0000);
    applyStimulus(0, 5'd0, 1, 0, 8'hD2);
    applyStimulus(0, 5'd0, 1, 0, 8'hD3);
    checkStatus("abort 3 bytes", 1, 0, 0, 6'd3);
    applyStimulus(1, 5'd0, 1, 0, 8'hEE);
    checkStatus("abort restart", 1, 0, 0, 6'd0);
    fetchCheck("abort word0", 3'd0, 32'h00D3_D2D1);
    checkOutput("hold fetch_data", fetch_data, 32'h00D3_D2D1);

    $display("[TB] reset mid-load");
    applyStimulus(0, 5'd0, 1, 0, 8'h99);
    checkStatus("preload", 1, 0, 0, 6'd1);
    #2;
    reset_code_rom_n = 1'b0;
    #1;
    checkStatus("midload reset", 0, 0, 0, 6'd0);
    checkOutput("midload fetch_data", fetch_data, 32'h0);
    @(posedge clk);
    #1;
    reset_code_rom_n = 1'b1;
    for (int w = 0; w < 8; w++)
      fetchCheck($sformatf("cleared word%0d", w), 3'(w), 32'h0000_0000);
    checkStatus("post reset", 0, 0, 0, 6'd0);
`ifdef CODE_MEM_CHECKSUM_EN
    checkOutput("post reset checksum", 32'(load_checksum), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
